multicycle_control_sequencer: RTL and testbench
===============================================

Name: multicycle_control_sequencer

Overview:
- Parametrised successor to the per-stage control-signal generator.
- Owns the instruction stage state machine (IF, ID, EX, MEM×N, WB) and the MEM-stage cycle counter, instead of taking stage and cycle as inputs.
- Gates decoder-supplied per-instruction flags into single-stage register, memory, I/O and stack-pointer strobes.
- Sits between the instruction decoder and the register file, data memory, I/O space and SP logic.

Parameters:
- CYCLE_W, 2: width of cycle_count and mem_cycles.
- MAX_MEM_CYCLES, 3: upper clamp on MEM-stage length. Must be ≥1 and ≤ 2^CYCLE_W.
- STAGE_W, 3: width of the encoded pipeline_stage output.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold current stage and count; suppress all strobes
- dec_rr_read  in  1  instruction reads Rr
- dec_rd_read  in  1  instruction reads Rd
- dec_rd_write  in  1  instruction writes Rd
- dec_mem_read  in  1  data-memory load
- dec_mem_write  in  1  data-memory store
- dec_io_read  in  1  I/O-space read
- dec_io_write  in  1  I/O-space write
- dec_io_write_early  in  1  I/O write issued in EX, not WB (ALU-aux class)
- dec_sp_postdec  in  1  SP post-decrement per MEM cycle (push/call class)
- dec_sp_preinc  in  1  SP pre-increment (pop/ret class)
- dec_mem_cycles  in  CYCLE_W  number of MEM cycles required
- pipeline_stage  out  STAGE_W  IF=0, ID=1, EX=2, MEM=3, WB=4
- cycle_count  out  CYCLE_W  index of current MEM cycle; 0 outside MEM
- reg_rr_read, reg_rd_read, reg_rd_write  out  1  register-file strobes
- mem_read, mem_write  out  1  data-memory strobes
- io_read, io_write  out  1  I/O-space strobes
- sp_postdec, sp_preinc  out  1  stack-pointer strobes
- instr_done  out  1  one-cycle pulse on the final WB cycle

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: stage=IF, cycle_count=0, latched flags=0, all strobes and instr_done=0. Reset mid-instruction abandons it with no further strobes.
- Transitions (each one clock, only when stall=0):
  - IF→ID, ID→EX, EX→MEM, WB→IF.
  - MEM: if cycle_count < eff_cycles−1, increment count and stay in MEM; else clear count and go to WB.
- eff_cycles: min(max(dec_mem_cycles,1), MAX_MEM_CYCLES), except as modified by the optional feature.
- Flag capture:
  - Decoder flags and eff_cycles are registered at the ID→EX edge and held until WB→IF.
  - In ID, strobes use the live dec_* inputs.
  - In EX, MEM and WB, strobes use the latched flags.
- Stall:
  - Freezes stage, count and latched flags.
  - Forces every strobe and instr_done to 0, so no write or SP step repeats.
  - Strobes resume once stall=0 in the same stage.
- Strobe timing (all combinational from stage, count and flags; stall=0 assumed):
  - reg_rr_read, reg_rd_read: ID.
  - reg_rd_write: WB.
  - io_read: EX.
  - io_write: EX if io_write_early, else WB. Never both.
  - mem_read, mem_write: every MEM cycle.
  - sp_postdec: every MEM cycle.
  - sp_preinc: EX and every MEM cycle except the last. A 1-cycle MEM gives EX only.
  - instr_done: WB.
- Contradictory flags (mem_read & mem_write): both strobes assert; the decoder must not generate this.
- Minimum instruction length: 5 cycles. Length is 4 + eff_cycles, excluding stall cycles.

Optional Feature:
- Macro: CTRL_SKIP_MEM_EN.
- Defined: a latched dec_mem_cycles==0 takes EX→WB directly with no MEM stage (4-cycle instruction). MEM-stage strobes never assert for that instruction. sp_preinc still asserts in EX if flagged.
- Undefined: 0 is treated as 1, as stated above.

Test Plan:
- reset=1 for 2 clocks, then idle decoder → stage sequence 0,1,2,3,4,0; all strobes 0; instr_done high only in cycle 5.
- ALU op (rr_read, rd_read, rd_write, mem_cycles=1) → rr/rd read in ID only, rd_write in WB only; 5-cycle period.
- Return-class (mem_read, sp_preinc, mem_cycles=2) → sp_preinc in EX and at MEM cycle_count=0; mem_read at count 0 and 1; WB in cycle 6.
- Push-class store (mem_write, sp_postdec, mem_cycles=1) with stall=1 for 3 clocks in MEM → stage held at 3, strobes 0 during stall, exactly one mem_write and one sp_postdec after release.
- io_write_early=1 versus 0 → io_write in EX versus WB, exactly one cycle each; reset asserted during MEM of a mem_cycles=3 instruction → next cycle stage=0, count=0, no strobes.
- CTRL_SKIP_MEM_EN defined with mem_cycles=0 → stages 0,1,2,4, mem strobes never asserted; undefined → stages 0,1,2,3,4.

Source files
------------

// File: rtl/multicycle_control_sequencer.sv
// Multicycle instruction sequencer: owns the IF/ID/EX/MEM*N/WB stage machine and gates decoder flags
// into single-stage strobes. Optional macro CTRL_SKIP_MEM_EN lets a zero MEM length bypass MEM entirely.
module multicycle_control_sequencer #(
   parameter int CYCLE_W        = 2,
   parameter int MAX_MEM_CYCLES = 3,
   parameter int STAGE_W        = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               dec_rr_read,
   input  logic               dec_rd_read,
   input  logic               dec_rd_write,
   input  logic               dec_mem_read,
   input  logic               dec_mem_write,
   input  logic               dec_io_read,
   input  logic               dec_io_write,
   input  logic               dec_io_write_early,
   input  logic               dec_sp_postdec,
   input  logic               dec_sp_preinc,
   input  logic [CYCLE_W-1:0] dec_mem_cycles,
   output logic [STAGE_W-1:0] pipeline_stage,
   output logic [CYCLE_W-1:0] cycle_count,
   output logic               reg_rr_read,
   output logic               reg_rd_read,
   output logic               reg_rd_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               io_read,
   output logic               io_write,
   output logic               sp_postdec,
   output logic               sp_preinc,
   output logic               instr_done
);

   // Encoding order matters: IF=0, ID=1, EX=2, MEM=3, WB=4 are visible on pipeline_stage.
   typedef enum logic [STAGE_W-1:0] {ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB} stage_e;

   typedef struct packed {
      logic rd_write;
      logic mem_read;
      logic mem_write;
      logic io_read;
      logic io_write;
      logic io_early;
      logic sp_postdec;
      logic sp_preinc;
   } flags_t;

   localparam logic [CYCLE_W:0] MAX_C = (CYCLE_W+1)'(MAX_MEM_CYCLES);

   stage_e             stage_q, stage_d;
   logic [CYCLE_W-1:0] count_q, count_d;
   logic [CYCLE_W-1:0] last_q, last_d;
   flags_t             flags_q, flags_d;
   flags_t             dec_flags_s;
   logic               skip_s;

   // Index of the final MEM cycle: clamp the requested length to [1, MAX_MEM_CYCLES], minus one.
   function automatic logic [CYCLE_W-1:0] eff_last(input logic [CYCLE_W-1:0] n);
      logic [CYCLE_W:0] e;
      if (n == '0) begin
         e = (CYCLE_W+1)'(1);
      end else if ({1'b0, n} > MAX_C) begin
         e = MAX_C;
      end else begin
         e = {1'b0, n};
      end
      return CYCLE_W'(e - (CYCLE_W+1)'(1));
   endfunction

   assign dec_flags_s = '{rd_write:   dec_rd_write,
                          mem_read:   dec_mem_read,
                          mem_write:  dec_mem_write,
                          io_read:    dec_io_read,
                          io_write:   dec_io_write,
                          io_early:   dec_io_write_early,
                          sp_postdec: dec_sp_postdec,
                          sp_preinc:  dec_sp_preinc};

`ifdef CTRL_SKIP_MEM_EN
   logic skip_q;

   // Remember, at the ID->EX edge, whether this instruction has no MEM stage at all.
   always_ff @(posedge clk) begin
      if (reset) begin
         skip_q <= 1'b0;
      end else if (!stall && stage_q == ST_ID) begin
         skip_q <= (dec_mem_cycles == '0);
      end else begin
         skip_q <= skip_q;
      end
   end

   assign skip_s = skip_q;
`else
   assign skip_s = 1'b0;
`endif

   // Stage / MEM-count / latched-flag next-state logic; everything freezes under stall.
   always_comb begin
      stage_d = stage_q;
      count_d = count_q;
      last_d  = last_q;
      flags_d = flags_q;
      if (!stall) begin
         case (stage_q)
            ST_IF: stage_d = ST_ID;
            ST_ID: begin
               stage_d = ST_EX;
               flags_d = dec_flags_s;
               last_d  = eff_last(dec_mem_cycles);
            end
            ST_EX: stage_d = skip_s ? ST_WB : ST_MEM;
            ST_MEM: begin
               if (count_q < last_q) begin
                  count_d = count_q + CYCLE_W'(1);
               end else begin
                  count_d = '0;
                  stage_d = ST_WB;
               end
            end
            ST_WB: begin
               stage_d = ST_IF;
               flags_d = '0;
               last_d  = '0;
            end
            default: begin
               stage_d = ST_IF;
               count_d = '0;
            end
         endcase
      end else begin
         stage_d = stage_q;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= ST_IF;
         count_q <= '0;
         last_q  <= '0;
         flags_q <= '0;
      end else begin
         stage_q <= stage_d;
         count_q <= count_d;
         last_q  <= last_d;
         flags_q <= flags_d;
      end
   end

   // Strobe decode: ID uses live decoder flags, later stages the latched copy.
   always_comb begin
      reg_rr_read  = 1'b0;
      reg_rd_read  = 1'b0;
      reg_rd_write = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      io_read      = 1'b0;
      io_write     = 1'b0;
      sp_postdec   = 1'b0;
      sp_preinc    = 1'b0;
      instr_done   = 1'b0;
      if (!stall) begin
         case (stage_q)
            ST_ID: begin
               reg_rr_read = dec_rr_read;
               reg_rd_read = dec_rd_read;
            end
            ST_EX: begin
               io_read   = flags_q.io_read;
               io_write  = flags_q.io_write & flags_q.io_early;
               sp_preinc = flags_q.sp_preinc;
            end
            ST_MEM: begin
               mem_read   = flags_q.mem_read;
               mem_write  = flags_q.mem_write;
               sp_postdec = flags_q.sp_postdec;
               sp_preinc  = flags_q.sp_preinc & (count_q != last_q);
            end
            ST_WB: begin
               reg_rd_write = flags_q.rd_write;
               io_write     = flags_q.io_write & ~flags_q.io_early;
               instr_done   = 1'b1;
            end
            default: begin
               instr_done = 1'b0;
            end
         endcase
      end else begin
         instr_done = 1'b0;
      end
   end

   assign pipeline_stage = stage_q;
   assign cycle_count    = count_q;

endmodule

// File: tb/tb_multicycle_control_sequencer.sv
// Directed plus randomized bench: expected per-cycle stage/count/strobes come from a cycle-index model.
module tb_multicycle_control_sequencer;

   localparam int CW   = 2;
   localparam int SW   = 3;
   localparam int MAXC = 3;

   logic          clk = 1'b0;
   logic          reset, stall;
   logic          dec_rr_read, dec_rd_read, dec_rd_write, dec_mem_read, dec_mem_write;
   logic          dec_io_read, dec_io_write, dec_io_write_early, dec_sp_postdec, dec_sp_preinc;
   logic [CW-1:0] dec_mem_cycles;
   logic [SW-1:0] pipeline_stage;
   logic [CW-1:0] cycle_count;
   logic          reg_rr_read, reg_rd_read, reg_rd_write, mem_read, mem_write;
   logic          io_read, io_write, sp_postdec, sp_preinc, instr_done;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic rr, rd, rdw, mr, mw, ior, iow, early, spd, spi;
   } fl_t;

   multicycle_control_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall),
      .dec_rr_read(dec_rr_read), .dec_rd_read(dec_rd_read), .dec_rd_write(dec_rd_write),
      .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
      .dec_io_read(dec_io_read), .dec_io_write(dec_io_write),
      .dec_io_write_early(dec_io_write_early),
      .dec_sp_postdec(dec_sp_postdec), .dec_sp_preinc(dec_sp_preinc),
      .dec_mem_cycles(dec_mem_cycles),
      .pipeline_stage(pipeline_stage), .cycle_count(cycle_count),
      .reg_rr_read(reg_rr_read), .reg_rd_read(reg_rd_read), .reg_rd_write(reg_rd_write),
      .mem_read(mem_read), .mem_write(mem_write),
      .io_read(io_read), .io_write(io_write),
      .sp_postdec(sp_postdec), .sp_preinc(sp_preinc), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   wire [9:0] strobes = {reg_rr_read, reg_rd_read, reg_rd_write, mem_read, mem_write,
                         io_read, io_write, sp_postdec, sp_preinc, instr_done};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle(input string tag, input int st, input int cnt, input logic [9:0] stb);
      check({tag, "/stage"},   16'(pipeline_stage), 16'(st));
      check({tag, "/count"},   16'(cycle_count),    16'(cnt));
      check({tag, "/strobes"}, 16'(strobes),        16'(stb));
   endtask

   // MEM-stage length the instruction should take (0 means MEM is bypassed).
   function automatic int eff_of(input int n);
`ifdef CTRL_SKIP_MEM_EN
      if (n == 0) return 0;
`endif
      if (n == 0) return 1;
      if (n > MAXC) return MAXC;
      return n;
   endfunction

   // Runs one instruction from its IF cycle; called and returns at a falling edge.
   task automatic run_instr(input string tag, input fl_t f, input int mc, input int stall_k,
                            input int stall_n, input bit rnd_stall, input int abort_k);
      int eff, len, st, cnt, ns;
      bit is_mem, is_wb;
      logic [9:0] e;
      dec_rr_read = f.rr;   dec_rd_read = f.rd;   dec_rd_write = f.rdw;
      dec_mem_read = f.mr;  dec_mem_write = f.mw;
      dec_io_read = f.ior;  dec_io_write = f.iow; dec_io_write_early = f.early;
      dec_sp_postdec = f.spd; dec_sp_preinc = f.spi;
      dec_mem_cycles = CW'(mc);
      eff = eff_of(mc);
      len = 4 + eff;
      for (int k = 0; k < len; k++) begin
         is_mem = (k >= 3) && (k < 3 + eff);
         is_wb  = (k == len - 1);
         st  = (k < 3) ? k : (is_mem ? 3 : 4);
         cnt = is_mem ? k - 3 : 0;
         e = {f.rr && k == 1, f.rd && k == 1, f.rdw && is_wb, f.mr && is_mem, f.mw && is_mem,
              f.ior && k == 2, f.iow && (f.early ? (k == 2) : is_wb), f.spd && is_mem,
              f.spi && ((k == 2) || (is_mem && (k - 3 < eff - 1))), is_wb};
         if (k == stall_k) ns = stall_n;
         else if (rnd_stall && $urandom_range(0, 3) == 0) ns = int'($urandom_range(1, 2));
         else ns = 0;
         for (int s = 0; s < ns; s++) begin
            stall = 1'b1;
            #1;
            check_cycle({tag, "/stall"}, st, cnt, 10'b0);
            @(negedge clk);
         end
         stall = 1'b0;
         #1;
         check_cycle(tag, st, cnt, e);
         if (k == abort_k) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            check_cycle({tag, "/abort"}, 0, 0, 10'b0);
            @(negedge clk);
            reset = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      fl_t f;
      logic [9:0] r;
      reset = 1'b1;
      stall = 1'b0;
      f = '0;
      dec_rr_read = 1'b0; dec_rd_read = 1'b0; dec_rd_write = 1'b0;
      dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_io_read = 1'b0; dec_io_write = 1'b0;
      dec_io_write_early = 1'b0; dec_sp_postdec = 1'b0; dec_sp_preinc = 1'b0;
      dec_mem_cycles = 2'd0;
      @(negedge clk);
      #1;
      check_cycle("reset", 0, 0, 10'b0);
      @(negedge clk);
      reset = 1'b0;

      run_instr("idle", '0, 1, -1, 0, 1'b0, -1);

      f = '0; f.rr = 1'b1; f.rd = 1'b1; f.rdw = 1'b1;
      run_instr("alu", f, 1, -1, 0, 1'b0, -1);

      f = '0; f.mr = 1'b1; f.spi = 1'b1;
      run_instr("ret", f, 2, -1, 0, 1'b0, -1);

      f = '0; f.mw = 1'b1; f.spd = 1'b1;
      run_instr("push_stall", f, 1, 3, 3, 1'b0, -1);

      f = '0; f.iow = 1'b1; f.early = 1'b1;
      run_instr("io_early", f, 1, -1, 0, 1'b0, -1);
      f.early = 1'b0;
      run_instr("io_late", f, 1, -1, 0, 1'b0, -1);

      f = '0; f.mr = 1'b1; f.mw = 1'b1; f.spd = 1'b1; f.spi = 1'b1;
      run_instr("mc0", f, 0, -1, 0, 1'b0, -1);

      f = '0; f.mr = 1'b1; f.spi = 1'b1; f.rdw = 1'b1;
      run_instr("abort", f, 3, -1, 0, 1'b0, 4);
      run_instr("after_abort", '0, 3, -1, 0, 1'b0, -1);

      for (int i = 0; i < 40; i++) begin
         r = 10'($urandom);
         f = r;
         run_instr("rand", f, int'($urandom_range(0, 3)), -1, 0, 1'b1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
